spi_adc_scan: RTL and testbench

Multi-channel successor to the single-channel SPI ADC test path. It scans a masked set of ADS7841-style 12-bit ADC channels over one SPI link. A scan is triggered either by a one-shot pulse or by an internal periodic timer. Each conversion result is delivered with its channel index on a valid/ready output port. The block sits between the trigger source (push-debounced single tick or free-running mode) and the downstream sample consumer.

---
 rtl/spi_adc_pkg.sv | 41 ++++
 rtl/spi_adc_scan_if.sv | 12 +
 rtl/spi_adc_xfer.sv | 95 +++++++++
 rtl/spi_adc_scan.sv | 164 ++++++++++++++++
 tb/tb_spi_adc_scan.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_pkg.sv
// Shared constants, state types and the command-byte helper for the SPI ADC scanner.
package spi_adc_pkg;

  localparam int unsigned NCH_MAX       = 4;
  localparam int unsigned DW            = 12;
  localparam int unsigned DIVW          = 8;
  localparam int unsigned PERW          = 29;
  localparam int unsigned CHW           = 2;
  localparam int unsigned PCW           = 5;

  localparam int unsigned FRAME_PERIODS = 24;
  localparam int unsigned CMD_BITS      = 8;
  localparam int unsigned SAMPLE_FIRST  = 10;
  localparam int unsigned SAMPLE_LAST   = 21;

  localparam logic [3:0] CMD_TAIL = 4'b0111;

  // Input-select code per channel, index 0 is channel 0
  localparam logic [NCH_MAX-1:0][2:0] CH_SEL = {3'b110, 3'b010, 3'b101, 3'b001};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_XFER,
    S_GAP,
    S_DONE
  } scan_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_LOW,
    PH_HIGH
  } xfer_phase_e;

  // Control byte sent to the converter for a given channel
  function automatic logic [CMD_BITS-1:0] make_cmd(input logic [CHW-1:0] ch);
    return {1'b1, CH_SEL[ch], CMD_TAIL};
  endfunction

endpackage

// File: rtl/spi_adc_scan_if.sv
// Result stream: sample plus channel index with valid/ready handshake.
interface spi_adc_scan_if;

  logic [spi_adc_pkg::DW-1:0]  data;
  logic [spi_adc_pkg::CHW-1:0] ch;
  logic                        valid;
  logic                        ready;

  modport master (output data, ch, valid, input ready);
  modport slave  (input data, ch, valid, output ready);

endinterface

// File: rtl/spi_adc_xfer.sv
// Single SPI frame: setup, 24 dclk periods, command out, 12-bit result in.
module spi_adc_xfer
  import spi_adc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                go,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic [DIVW-1:0]     kmax,
  input  logic                miso,
  output logic                cs,
  output logic                dclk,
  output logic                mosi,
  output logic [DW-1:0]       result,
  output logic                done_c
);

  xfer_phase_e         phase, phase_n;
  logic [DIVW-1:0]     hcnt;
  logic [PCW-1:0]      pcnt;
  logic [CMD_BITS-1:0] cmd_sr;
  logic                half_end_c;
  logic                last_c;
  logic                enter_low_c;
  logic                samp_c;

  assign half_end_c  = (hcnt == kmax);
  assign last_c      = (pcnt == PCW'(FRAME_PERIODS));
  assign enter_low_c = (phase_n == PH_LOW) && (phase != PH_LOW);
  assign samp_c      = (phase == PH_LOW) && half_end_c &&
                       (pcnt >= PCW'(SAMPLE_FIRST)) && (pcnt <= PCW'(SAMPLE_LAST));

  // Phase register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase <= PH_IDLE;
    else       phase <= phase_n;
  end

  // Phase sequencing; done_c marks the last cycle with cs low
  always_comb begin
    phase_n = phase;
    done_c  = 1'b0;
    case (phase)
      PH_IDLE:  if (go) phase_n = PH_SETUP;
      PH_SETUP: if (half_end_c) phase_n = PH_LOW;
      PH_LOW:   if (half_end_c) phase_n = PH_HIGH;
      PH_HIGH: begin
        if (half_end_c) begin
          if (last_c) begin
            phase_n = PH_IDLE;
            done_c  = 1'b1;
          end else begin
            phase_n = PH_LOW;
          end
        end
      end
      default:  phase_n = PH_IDLE;
    endcase
  end

  // Half-period divider, pins and shift registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt   <= '0;
      pcnt   <= '0;
      cmd_sr <= '0;
      result <= '0;
      cs     <= 1'b1;
      dclk   <= 1'b0;
      mosi   <= 1'b0;
    end else begin
      hcnt <= ((phase == PH_IDLE) || half_end_c) ? '0 : hcnt + DIVW'(1);
      if ((phase == PH_IDLE) && go) begin
        cs     <= 1'b0;
        cmd_sr <= cmd;
        pcnt   <= '0;
      end
      // Command bits drain MSB-first; the register is empty after 8 shifts
      if (enter_low_c) begin
        dclk   <= 1'b0;
        mosi   <= cmd_sr[CMD_BITS-1];
        cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
        pcnt   <= pcnt + PCW'(1);
      end
      if ((phase == PH_LOW) && half_end_c) dclk <= 1'b1;
      if (samp_c) result <= {result[DW-2:0], miso};
      if (done_c) begin
        cs   <= 1'b1;
        dclk <= 1'b0;
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_adc_scan.sv
// Multi-channel ADC scanner: trigger/timer, scan FSM, channel pick, result register.
module spi_adc_scan
  import spi_adc_pkg::*;
#(
  parameter int unsigned NCH = NCH_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              auto_i,
  input  logic [PERW-1:0]   period_i,
  input  logic [DIVW-1:0]   kmax_i,
  input  logic [NCH-1:0]    ch_mask_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              dclk_o,
  output logic              cs_o,
  spi_adc_scan_if.master    out_if,
  output logic              busy_o,
  output logic              eos_o,
  output logic              ovr_o
);

  scan_state_e         state, state_n;
  logic [PERW-1:0]     timer;
  logic [PERW-1:0]     period_q;
  logic [DIVW-1:0]     kmax_q;
  logic [DIVW-1:0]     gap_cnt;
  logic [NCH-1:0]      rem_mask;
  logic [CHW-1:0]      cur_ch;
  logic [CHW-1:0]      sel_c;
  logic                found_c;
  logic                go_c;
  logic                fire_c;
  logic                acc_c;
  logic                load_c;
  logic                xfer_done_c;
  logic [CMD_BITS-1:0] cmd_c;
  logic [DW-1:0]       result;
  logic [DW-1:0]       data_q;
  logic [CHW-1:0]      ch_q;
  logic                valid_q;

  assign fire_c = auto_i && (timer == period_q);
  assign acc_c  = (state == S_IDLE) && (start_i || fire_c);
  assign load_c = (state == S_XFER) && xfer_done_c;
  assign cmd_c  = make_cmd(sel_c);

  assign out_if.data  = data_q;
  assign out_if.ch    = ch_q;
  assign out_if.valid = valid_q;

  // Lowest-index channel still pending in this scan
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (rem_mask[i]) begin
        found_c = 1'b1;
        sel_c   = CHW'(i);
      end
    end
  end

  // Scan state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  // Scan next-state and frame launch
  always_comb begin
    state_n = state;
    go_c    = 1'b0;
    case (state)
      S_IDLE: if (acc_c) state_n = S_PICK;
      S_PICK: begin
        if (found_c) begin
          state_n = S_XFER;
          go_c    = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      S_XFER: if (xfer_done_c) state_n = S_GAP;
      S_GAP:  if (gap_cnt == '0) state_n = S_PICK;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Periodic trigger timer, restarted by every accepted trigger
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer    <= '0;
      period_q <= '0;
    end else begin
      if (!auto_i)               timer <= '0;
      else if (acc_c || fire_c)  timer <= '0;
      else                       timer <= timer + PERW'(1);
      if (!auto_i || acc_c) period_q <= period_i;
    end
  end

  // Per-scan snapshot of mask and divider, channel bookkeeping, gap counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_mask <= '0;
      kmax_q   <= '0;
      cur_ch   <= '0;
      gap_cnt  <= '0;
    end else begin
      if (acc_c) begin
        rem_mask <= ch_mask_i;
        kmax_q   <= kmax_i;
      end
      if (go_c) begin
        rem_mask[sel_c] <= 1'b0;
        cur_ch          <= sel_c;
      end
      if (load_c)                                   gap_cnt <= kmax_q;
      else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - DIVW'(1);
    end
  end

  // Result register with overwrite-on-overrun and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ovr_o   <= 1'b0;
      busy_o  <= 1'b0;
      eos_o   <= 1'b0;
    end else begin
      if (load_c) begin
        data_q  <= result;
        ch_q    <= cur_ch;
        valid_q <= 1'b1;
        if (valid_q && !out_if.ready) ovr_o <= 1'b1;
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
      if (acc_c && start_i) ovr_o <= 1'b0;
      busy_o <= (state_n != S_IDLE);
      eos_o  <= (state == S_PICK) && !found_c;
    end
  end

  spi_adc_xfer u_xfer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .go     (go_c),
    .cmd    (cmd_c),
    .kmax   (kmax_q),
    .miso   (miso_i),
    .cs     (cs_o),
    .dclk   (dclk_o),
    .mosi   (mosi_o),
    .result (result),
    .done_c (xfer_done_c)
  );

endmodule

// File: tb/tb_spi_adc_scan.sv
// Directed and randomized checks of spi_adc_scan against an ADC and scan model.
module tb_spi_adc_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic [28:0] period = '0;
  logic [7:0]  kmax = '0;
  logic [3:0]  mask = '0;
  logic        miso = 1'b0;
  logic        mosi, dclk, cs, busy, eos, ovr;
  logic        rdy = 1'b1;
  bit          rnd_rdy = 1'b0;

  spi_adc_scan_if u_if ();
  assign u_if.ready = rdy;

  spi_adc_scan #(.NCH(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .auto_i    (auto_en),
    .period_i  (period),
    .kmax_i    (kmax),
    .ch_mask_i (mask),
    .miso_i    (miso),
    .mosi_o    (mosi),
    .dclk_o    (dclk),
    .cs_o      (cs),
    .out_if    (u_if.master),
    .busy_o    (busy),
    .eos_o     (eos),
    .ovr_o     (ovr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: decodes the control byte, returns adc_mem[channel] MSB-first in periods 10..21
  logic [11:0] adc_mem [4];
  logic [7:0]  cmd_tab [4] = '{8'h97, 8'hD7, 8'hA7, 8'hE7};
  logic [7:0]  adc_cmd = '0;
  logic [7:0]  cmd_q [$];
  logic [7:0]  exp_cmd_q [$];
  logic [13:0] got_q [$];
  logic [13:0] exp_q [$];
  int          cs_fall [$];
  int          adc_r = 0, flen = 0, hrun = 0, exp_h = 2, nframes = 0, mon_p = 0;
  bit          in_frame = 1'b0;
  logic        pdclk = 1'b0, pcs = 1'b1;
  logic [11:0] mon_v;

  function automatic int sel2ch(input logic [2:0] s);
    case (s)
      3'b001:  return 0;
      3'b101:  return 1;
      3'b010:  return 2;
      3'b110:  return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      adc_r    = 0;
      hrun     = 0;
      miso     = 1'b0;
    end else begin
      if (pcs && !cs) cs_fall.push_back(cyc);
      if (cs) begin
        if (in_frame) begin
          check("frame_len", 32'(flen), 32'(49 * exp_h));
          nframes++;
        end
        in_frame = 1'b0;
        adc_r    = 0;
        hrun     = 0;
        miso     = 1'b0;
      end else begin
        if (!in_frame) begin
          in_frame = 1'b1;
          flen     = 0;
          adc_cmd  = '0;
        end
        flen++;
        if (dclk && !pdclk) begin
          adc_r++;
          if (adc_r <= 8) begin
            adc_cmd = {adc_cmd[6:0], mosi};
            if (adc_r == 8) cmd_q.push_back(adc_cmd);
          end
        end
        if (dclk) hrun++;
        else if (pdclk) begin
          check("dclk_high", 32'(hrun), 32'(exp_h));
          hrun = 0;
        end
        mon_p = adc_r + 1;
        if (mon_p >= 10 && mon_p <= 21) begin
          mon_v = adc_mem[sel2ch(adc_cmd[6:4])];
          miso  = mon_v[21 - mon_p];
        end else begin
          miso = 1'b0;
        end
      end
    end
    pdclk = dclk;
    pcs   = cs;
  end

  // Consumer side: every handshake is a delivered beat
  always @(negedge clk) begin
    if (!rst && u_if.valid && u_if.ready) got_q.push_back({u_if.ch, u_if.data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},    32'(cs),         32'd1);
    check({tag, "_dclk"},  32'(dclk),       32'd0);
    check({tag, "_mosi"},  32'(mosi),       32'd0);
    check({tag, "_data"},  32'(u_if.data),  32'd0);
    check({tag, "_ch"},    32'(u_if.ch),    32'd0);
    check({tag, "_valid"}, 32'(u_if.valid), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_eos"},   32'(eos),        32'd0);
    check({tag, "_ovr"},   32'(ovr),        32'd0);
  endtask

  // One start-triggered scan; expected beats come from the mask in ascending order
  task automatic run_scan(input logic [3:0] m, input int km);
    int n;
    int k;
    mask  = m;
    kmax  = 8'(km);
    exp_h = km + 1;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        exp_q.push_back({2'(c), adc_mem[c]});
        exp_cmd_q.push_back(cmd_tab[c]);
        k++;
      end
    end
    start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_at_T1", 32'(busy), 32'd1);
      end
      if (n == 2) check("cs_at_T2", 32'(cs), (k > 0) ? 32'd0 : 32'd1);
    end while (!eos && n < 3000);
    check("eos_latency", 32'(n), 32'(2 + k * (1 + 50 * (km + 1))));
    tick();
    check("eos_width", 32'(eos), 32'd0);
  endtask

  task automatic compare_beats(input string tag);
    for (int i = 0; i < 400 && u_if.valid; i++) tick();
    check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_ncmd"}, 32'(cmd_q.size()), 32'(exp_cmd_q.size()));
    for (int i = 0; i < exp_cmd_q.size() && i < cmd_q.size(); i++)
      check({tag, "_cmd"}, 32'(cmd_q[i]), 32'(exp_cmd_q[i]));
    got_q.delete();
    exp_q.delete();
    cmd_q.delete();
    exp_cmd_q.delete();
  endtask

  initial begin
    int f0;
    int w;
    adc_mem = '{12'hABC, 12'h123, 12'h456, 12'h789};

    // Reset state
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Golden two-channel scan
    run_scan(4'b0011, 1);
    compare_beats("golden");
    check("golden_ovr", 32'(ovr), 32'd0);

    // Empty mask: eos only, no SPI traffic
    f0 = nframes;
    run_scan(4'b0000, 1);
    check("empty_frames", 32'(nframes), 32'(f0));
    check("empty_cs", 32'(cs), 32'd1);
    compare_beats("empty");

    // Periodic mode with ignored start pulses while busy
    period = 29'd999;
    mask   = 4'b0001;
    kmax   = 8'd1;
    exp_h  = 2;
    cs_fall.delete();
    auto_en = 1'b1;
    for (int i = 0; i < 3400; i++) begin
      start = busy && (i % 13 == 0);
      tick();
    end
    start   = 1'b0;
    auto_en = 1'b0;
    for (w = 0; w < 500 && busy; w++) tick();
    repeat (4) tick();
    check("auto_falls_ge3", 32'(cs_fall.size() >= 3), 32'd1);
    for (int i = 1; i < cs_fall.size(); i++)
      check("auto_interval", 32'(cs_fall[i] - cs_fall[i-1]), 32'd1000);
    check("auto_nbeats", 32'(got_q.size()), 32'(cs_fall.size()));
    foreach (got_q[i]) check("auto_beat", 32'(got_q[i]), 32'({2'd0, adc_mem[0]}));
    got_q.delete();
    cmd_q.delete();

    // Overrun: consumer stalled for a whole two-channel scan
    for (int c = 0; c < 4; c++) adc_mem[c] = 12'($urandom);
    rdy = 1'b0;
    run_scan(4'b0011, 2);
    check("ovr_valid", 32'(u_if.valid), 32'd1);
    check("ovr_data",  32'(u_if.data),  32'(adc_mem[1]));
    check("ovr_ch",    32'(u_if.ch),    32'd1);
    check("ovr_flag",  32'(ovr),        32'd1);
    exp_q.delete();
    exp_cmd_q.delete();
    cmd_q.delete();
    rdy = 1'b1;
    tick();
    check("ovr_drain_n",   32'(got_q.size()), 32'd1);
    check("ovr_drain_beat", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'({2'd1, adc_mem[1]}));
    check("ovr_drain_valid", 32'(u_if.valid), 32'd0);
    check("ovr_sticky", 32'(ovr), 32'd1);
    got_q.delete();
    run_scan(4'b0000, 0);
    check("ovr_cleared", 32'(ovr), 32'd0);

    // Reset in the middle of a frame
    mask  = 4'b0001;
    kmax  = 8'd1;
    exp_h = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (w = 0; w < 400 && adc_r < 12; w++) tick();
    check("reach_period12", 32'(adc_r), 32'd12);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    cmd_q.delete();
    for (int c = 0; c < 4; c++) adc_mem[c] = 12'($urandom);
    run_scan(4'b1010, 2);
    compare_beats("post_reset");

    // Randomized masks, dividers and consumer back-pressure
    rnd_rdy = 1'b1;
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < 4; c++) adc_mem[c] = 12'($urandom);
      run_scan(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
      compare_beats("rand");
      check("rand_ovr", 32'(ovr), 32'd0);
    end
    rnd_rdy = 1'b0;
    rdy = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
